// File: rtl/injector_pkg.sv
// Shared definitions for the injector sequencer: register map, generator modes,
// latch FSM state encodings, control register layout and the PRBS7 step.
package injector_pkg;

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_DIV   = 2'd1;
    localparam logic [1:0] ADDR_TRIM  = 2'd2;
    localparam logic [1:0] ADDR_BURST = 2'd3;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_SQUARE = 2'd1;
    localparam logic [1:0] MODE_PRBS   = 2'd2;
    localparam logic [1:0] MODE_BURST  = 2'd3;

    localparam logic [6:0] PRBS_SEED = 7'h7F;

    // STROBE is the only state with bit 1 set, so latch_o can come straight off a flop.
    localparam logic [1:0] LS_IDLE   = 2'b00;
    localparam logic [1:0] LS_SETUP  = 2'b01;
    localparam logic [1:0] LS_STROBE = 2'b10;

    typedef struct packed {
        logic       level;
        logic [1:0] mode;
        logic       run;
    } ctrl_t;

    // x^7 + x^6 + 1, shift left, new bit enters at bit 0.
    function automatic logic [6:0] prbs7_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

endpackage

// File: rtl/injector_trim_latch.sv
// Trim latch sequencer: holds trim outputs stable for SETUP_CYC cycles, then
// strobes latch_o for LATCH_CYC cycles. Trim writes arriving while busy are dropped.
module injector_trim_latch
    import injector_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int LATCH_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trim_wr,
    input  logic [7:0] trim_data,
    output logic       cfg_busy,
    output logic [3:0] trim_p_o,
    output logic [3:0] trim_n_o,
    output logic       latch_o,
    output logic       trimmed_once
);

    localparam int CNT_MAX = (SETUP_CYC > LATCH_CYC) ? SETUP_CYC : LATCH_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LS_IDLE;
            cnt          <= '0;
            trim_p_o     <= '0;
            trim_n_o     <= '0;
            trimmed_once <= 1'b0;
        end else begin
            case (state)
                LS_IDLE: begin
                    if (trim_wr) begin
                        trim_p_o <= trim_data[3:0];
                        trim_n_o <= trim_data[7:4];
                        cnt      <= '0;
                        state    <= LS_SETUP;
                    end
                end
                LS_SETUP: begin
                    if (cnt == CNT_W'(SETUP_CYC - 1)) begin
                        cnt          <= '0;
                        state        <= LS_STROBE;
                        trimmed_once <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LS_STROBE: begin
                    if (cnt == CNT_W'(LATCH_CYC - 1)) begin
                        cnt   <= '0;
                        state <= LS_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= LS_IDLE;
            endcase
        end
    end

    assign latch_o  = state[1];
    assign cfg_busy = |state;

endmodule

// File: rtl/injector_seq.sv
// Bias injector sequencer: register port, trim latch sequencing and inject waveform
// generator (static/square/PRBS7/burst). Define INJECTOR_SEQ_PRBS_EN to build the PRBS7 mode.
module injector_seq
    import injector_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int LATCH_CYC = 2,
    parameter int DIV_W     = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [DIV_W-1:0] cfg_wdata,
    output logic             cfg_busy,
    output logic             enable_o,
    output logic [3:0]       trim_p_o,
    output logic [3:0]       trim_n_o,
    output logic             latch_o,
    output logic             signal_o,
    output logic             burst_done_o
);

    ctrl_t            ctrl_q;
    ctrl_t            ctrl_n;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] burst_n_q;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] pulse_cnt;
    logic [DIV_W:0]   pulses_next;
    logic             ctrl_wr;
    logic             trim_wr;
    logic             reload;
    logic             sym_end;
    logic             trimmed_once;
    logic             first_sym;
    logic             first_done;
    logic             prbs_first;
    logic             prbs_next;

    assign ctrl_wr     = cfg_we && (cfg_addr == ADDR_CTRL);
    assign trim_wr     = cfg_we && (cfg_addr == ADDR_TRIM);
    assign ctrl_n      = ctrl_wr ? ctrl_t'(cfg_wdata[3:0]) : ctrl_q;
    // Generator restarts on every CTRL write and sits at its reload point while stopped.
    assign reload      = ctrl_wr || !ctrl_n.run;
    assign sym_end     = (div_cnt == '0);
    assign pulses_next = {1'b0, pulse_cnt} + (DIV_W + 1)'(1);

    injector_trim_latch #(
        .SETUP_CYC (SETUP_CYC),
        .LATCH_CYC (LATCH_CYC)
    ) u_trim_latch (
        .clk          (wb_clk_i),
        .rst          (wb_rst_i),
        .trim_wr      (trim_wr),
        .trim_data    (cfg_wdata[7:0]),
        .cfg_busy     (cfg_busy),
        .trim_p_o     (trim_p_o),
        .trim_n_o     (trim_n_o),
        .latch_o      (latch_o),
        .trimmed_once (trimmed_once)
    );

`ifdef INJECTOR_SEQ_PRBS_EN
    logic [6:0] lfsr;
    logic [6:0] lfsr_step;

    assign lfsr_step  = prbs7_step(lfsr);
    assign prbs_first = PRBS_SEED[6];
    assign prbs_next  = lfsr_step[6];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || reload) begin
            lfsr <= PRBS_SEED;
        end else if (sym_end && (ctrl_q.mode == MODE_PRBS)) begin
            lfsr <= lfsr_step;
        end
    end
`else
    assign prbs_first = 1'b0;
    assign prbs_next  = 1'b0;
`endif

    // First symbol of the waveform, presented the cycle after the CTRL write.
    always_comb begin
        // NOTE: defaults first so no path leaves these unassigned and infers a latch.
        first_sym  = 1'b0;
        first_done = 1'b0;
        if (ctrl_n.run) begin
            case (ctrl_n.mode)
                MODE_STATIC: first_sym = ctrl_n.level;
                MODE_SQUARE: first_sym = 1'b1;
                MODE_PRBS:   first_sym = prbs_first;
                MODE_BURST: begin
                    first_sym  = (burst_n_q != '0);
                    first_done = (burst_n_q == '0);
                end
                default: first_sym = 1'b0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_q       <= '0;
            div_q        <= '0;
            burst_n_q    <= '0;
            div_cnt      <= '0;
            pulse_cnt    <= '0;
            enable_o     <= 1'b0;
            signal_o     <= 1'b0;
            burst_done_o <= 1'b0;
        end else begin
            ctrl_q <= ctrl_n;
            if (cfg_we && (cfg_addr == ADDR_DIV))   div_q     <= cfg_wdata;
            if (cfg_we && (cfg_addr == ADDR_BURST)) burst_n_q <= cfg_wdata;
            enable_o <= ctrl_n.run & trimmed_once;

            if (reload) begin
                div_cnt      <= div_q;
                pulse_cnt    <= '0;
                signal_o     <= first_sym;
                burst_done_o <= first_done;
            end else if (!sym_end) begin
                div_cnt <= div_cnt - DIV_W'(1);
            end else begin
                div_cnt <= div_q;
                case (ctrl_q.mode)
                    MODE_STATIC: signal_o <= ctrl_q.level;
                    MODE_SQUARE: signal_o <= ~signal_o;
                    MODE_PRBS:   signal_o <= prbs_next;
                    MODE_BURST: begin
                        // A pulse completes at the end of its low half.
                        if (!burst_done_o) begin
                            if (signal_o) begin
                                signal_o <= 1'b0;
                            end else if (pulses_next >= {1'b0, burst_n_q}) begin
                                burst_done_o <= 1'b1;
                            end else begin
                                signal_o  <= 1'b1;
                                pulse_cnt <= pulses_next[DIV_W-1:0];
                            end
                        end
                    end
                    default: signal_o <= 1'b0;
                endcase
            end
        end
    end

endmodule
